// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte producers.
// A requester is picked round-robin, and its byte is taken with a one-cycle
// ready pulse. A one-cycle DV strobe then goes to the transmitter, and the
// frame is followed through the transmitter's active and done flags.
// Define UART_ARB_FIXED_PRIO_EN to get fixed lowest-index priority instead
// of round-robin.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [NUM_REQ-1:0]     i_REQ_VALID,
  input  logic [8*NUM_REQ-1:0]   i_REQ_BYTE,
  output logic [NUM_REQ-1:0]     o_REQ_READY,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_BYTE,
  input  logic                   i_TX_ACTIVE,
  input  logic                   i_TX_DONE,
  output logic [GRANT_W-1:0]     o_GRANT_ID,
  output logic                   o_BUSY
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_ACTIVE = 2'd1;
  localparam logic [1:0] WAIT_DONE   = 2'd2;
  localparam logic [1:0] WAIT_IDLE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [GRANT_W-1:0] win_idx;
  logic               grant_go;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Winner search: lowest-index valid requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && i_REQ_VALID[i]) begin
        win_found = 1'b1;
        win_idx   = GRANT_W'(i);
      end
    end
  end
`else
  localparam logic [GRANT_W-1:0] PTR_RST = GRANT_W'(NUM_REQ - 1);

  logic [GRANT_W-1:0] ptr_q, ptr_d;
  int unsigned        cand;

  // Winner search: first valid requester upward from ptr+1, wrapping at NUM_REQ-1
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && i_REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = GRANT_W'(cand);
      end
    end
  end

  // Pointer follows the last winner so that it has lowest priority next time
  always_comb begin
    ptr_d = ptr_q;
    if (grant_go) begin
      ptr_d = win_idx;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      ptr_q <= PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // The transmitter must report fully idle before a grant, so a strobe never lands
  // on a frame still in progress. This also covers a frame that outlives a reset.
  assign grant_go = (state_q == IDLE) && win_found && !i_TX_ACTIVE && !i_TX_DONE;

  // Frame-tracking FSM and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    ready_d = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (grant_go) begin
          ready_d[win_idx] = 1'b1;
          dv_d             = 1'b1;
          byte_d           = i_REQ_BYTE[8*win_idx +: 8];
          grant_d          = win_idx;
          state_d          = WAIT_ACTIVE;
        end
      end
      WAIT_ACTIVE: begin
        if (i_TX_ACTIVE) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_TX_DONE) begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!i_TX_DONE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      ready_q <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign o_REQ_READY = ready_q;
  assign o_TX_DV     = dv_q;
  assign o_TX_BYTE   = byte_q;
  assign o_GRANT_ID  = grant_q;
  assign o_BUSY      = busy_q;

endmodule
